// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//
// Z80 I/O-mapped SPI master, the parametrised successor of the single-card MMC
// SPI port. A data port exchanges one byte per transfer; a control port drives
// the chip-selects, clears the overrun flag and returns status.
//
// Optional build macro: SPI_READ_TRIGGER_EN
//   defined   - a read of the data port while idle returns the current receive
//               byte and starts a new transfer sending 8'hFF (pipelined read).
//   undefined - only data-port writes start transfers.
//
// Parameters
//   CS_COUNT  number of active-low chip-selects (1..8)
//   DIV       SCK half-period is DIV+1 clock cycles (0..255)
//   MODE      0 = CPOL0/CPHA0, 3 = CPOL1/CPHA1
//   DATA_PORT low address byte of the data port
//   CTRL_PORT low address byte of the control/status port
//
// Ports
//   clock   system clock
//   reset   synchronous reset, active low
//   iorq    Z80 IORQ, active low
//   rd      Z80 RD, active low
//   wr      Z80 WR, active low
//   a       CPU address [7:0]
//   di      CPU write data
//   dout    read data towards the CPU data mux (the bus "do" signal; 8'hFF
//           whenever sel is low)
//   sel     high while a read of either port is in progress
//   spiCs   chip-selects, active low
//   spiCk   SCK
//   spiDi   MOSI
//   spiDo   MISO
//   busy    transfer in progress
//
// Status byte on a control-port read: {busy, ovr, 1'b0, ~spiCs[4:0]} with the
// chip-select field zero-extended when CS_COUNT < 5.
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int         CS_COUNT  = 2,
  parameter int         DIV       = 0,
  parameter int         MODE      = 0,
  parameter logic [7:0] DATA_PORT = 8'hEB,
  parameter logic [7:0] CTRL_PORT = 8'hE7
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iorq,
  input  logic                rd,
  input  logic                wr,
  input  logic [7:0]          a,
  input  logic [7:0]          di,
  output logic [7:0]          dout,
  output logic                sel,
  output logic [CS_COUNT-1:0] spiCs,
  output logic                spiCk,
  output logic                spiDi,
  input  logic                spiDo,
  output logic                busy
);

  // Mode 3 idles SCK high and samples on the second edge of each bit.
  localparam logic       CPOL        = (MODE == 3);
  localparam logic       CPHA        = (MODE == 3);
  localparam logic [7:0] HALF        = DIV[7:0];
  localparam int         CSW         = (CS_COUNT < 5) ? CS_COUNT : 5;
  localparam logic [3:0] LAST_SAMPLE = CPHA ? 4'd15 : 4'd14;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state;
  logic [7:0]  tx;
  logic [7:0]  rx;
  logic [7:0]  rxShift;
  logic        ovr;
  logic [7:0]  hc;
  logic [3:0]  bc;

  logic        wrS;
  logic        rdS;
  logic        wrD;
  logic        wrEv;
  logic        dataHit;
  logic        ctrlHit;
  logic        ctrlWrite;
  logic        dataWrite;
  logic        dataRead;
  logic        startEv;
  logic [7:0]  startByte;
  logic        halfEnd;
  logic        sampleEdge;
  logic        shiftEdge;
  logic        lastHalf;
  logic        lastSample;
  logic [4:0]  statusCs;

`ifdef SPI_READ_TRIGGER_EN
  logic        rdD;
  logic        rdEv;
`endif

  assign wrS     = ~iorq & ~wr;
  assign rdS     = ~iorq & ~rd;
  assign dataHit = (a == DATA_PORT);
  assign ctrlHit = (a == CTRL_PORT);

  // An access event is the first cycle of a strobe, so a long Z80 cycle
  // still produces exactly one event.
  assign wrEv = wrS & ~wrD;
`ifdef SPI_READ_TRIGGER_EN
  assign rdEv = rdS & ~rdD;
`endif

  // Decode bus events into control writes, data writes and transfer starts.
  always_comb begin
    ctrlWrite = wrEv & ctrlHit;
    dataWrite = wrEv & dataHit;
`ifdef SPI_READ_TRIGGER_EN
    dataRead  = rdEv & dataHit;
`else
    dataRead  = 1'b0;
`endif
    startEv   = (state == IDLE) & (dataWrite | dataRead);
    if (dataWrite) begin
      startByte = di;
    end else begin
      startByte = 8'hFF;
    end
  end

  // Classify the SCK edge that ends the current half-period. bc counts
  // half-periods 0..15; with CPHA=0 the even ones end in a sample edge,
  // with CPHA=1 the odd ones do. The very first CPHA=1 edge only "drives"
  // tx[7], which is already on MOSI, so it must not shift.
  always_comb begin
    halfEnd    = (hc == 8'd0);
    sampleEdge = (bc[0] == CPHA);
    shiftEdge  = ~sampleEdge & ~(CPHA & (bc == 4'd0));
    lastHalf   = (bc == 4'd15);
    lastSample = (bc == LAST_SAMPLE);
  end

  // Bus edge detectors, control register and the transfer state machine.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wrD     <= 1'b0;
`ifdef SPI_READ_TRIGGER_EN
      rdD     <= 1'b0;
`endif
      state   <= IDLE;
      spiCs   <= {CS_COUNT{1'b1}};
      spiCk   <= CPOL;
      spiDi   <= 1'b1;
      busy    <= 1'b0;
      tx      <= 8'hFF;
      rx      <= 8'hFF;
      rxShift <= 8'hFF;
      ovr     <= 1'b0;
      hc      <= 8'd0;
      bc      <= 4'd0;
    end else begin
      wrD <= wrS;
`ifdef SPI_READ_TRIGGER_EN
      rdD <= rdS;
`endif

      // Chip-selects may change at any time, even mid-transfer.
      if (ctrlWrite) begin
        spiCs <= ~di[CS_COUNT-1:0];
        if (di[7]) begin
          ovr <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (startEv) begin
            state <= SHIFT;
            busy  <= 1'b1;
            tx    <= startByte;
            spiDi <= startByte[7];
            hc    <= HALF;
            bc    <= 4'd0;
          end
        end

        SHIFT: begin
          // A data write during a transfer is dropped and flagged.
          if (dataWrite) begin
            ovr <= 1'b1;
          end

          if (halfEnd) begin
            hc <= HALF;
            bc <= bc + 4'd1;

            if (sampleEdge) begin
              rxShift <= {rxShift[6:0], spiDo};
              if (lastSample) begin
                rx <= {rxShift[6:0], spiDo};
              end
            end else if (shiftEdge) begin
              tx    <= {tx[6:0], 1'b1};
              spiDi <= tx[6];
            end

            // The final edge returns SCK to its idle level instead of
            // toggling, which is the same level either way; MOSI idles high.
            if (lastHalf) begin
              state <= IDLE;
              busy  <= 1'b0;
              spiCk <= CPOL;
              spiDi <= 1'b1;
            end else begin
              spiCk <= ~spiCk;
            end
          end else begin
            hc <= hc - 8'd1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          spiCk <= CPOL;
          spiDi <= 1'b1;
        end
      endcase
    end
  end

  // Combinational read-back mux towards the CPU data bus.
  always_comb begin
    statusCs          = 5'd0;
    statusCs[CSW-1:0] = ~spiCs[CSW-1:0];
    sel               = rdS & (dataHit | ctrlHit);
    if (!sel) begin
      dout = 8'hFF;
    end else if (dataHit) begin
      dout = rx;
    end else begin
      dout = {busy, ovr, 1'b0, statusCs};
    end
  end

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

  logic       clock = 1'b0;
  logic       reset;
  logic       iorq;
  logic       rd;
  logic       wr;
  logic [7:0] a;
  logic [7:0] di;

  logic [7:0] dout0, dout1;
  logic       sel0, sel1;
  logic [1:0] cs0, cs1;
  logic       ck0, ck1;
  logic       mosi0, mosi1;
  logic       miso0, miso1;
  logic       busy0, busy1;

  // Slave-side shift registers and MOSI capture, owned by the main process.
  logic [7:0] misoSr0 = 8'hFF;
  logic [7:0] misoSr1 = 8'hFF;
  logic [7:0] cap0 = 8'h00;
  logic [7:0] cap1 = 8'h00;

  assign miso0 = misoSr0[7];
  assign miso1 = misoSr1[7];

  always #5 clock = ~clock;

  // Instance 0: mode 0, fastest SCK, default ports.
  spi_master #(.CS_COUNT(2), .DIV(0), .MODE(0), .DATA_PORT(8'hEB), .CTRL_PORT(8'hE7)) u0 (
    .clock(clock), .reset(reset), .iorq(iorq), .rd(rd), .wr(wr), .a(a), .di(di),
    .dout(dout0), .sel(sel0), .spiCs(cs0), .spiCk(ck0), .spiDi(mosi0), .spiDo(miso0),
    .busy(busy0)
  );

  // Instance 1: mode 3, DIV=3, relocated ports.
  spi_master #(.CS_COUNT(2), .DIV(3), .MODE(3), .DATA_PORT(8'hDB), .CTRL_PORT(8'hD7)) u1 (
    .clock(clock), .reset(reset), .iorq(iorq), .rd(rd), .wr(wr), .a(a), .di(di),
    .dout(dout1), .sel(sel1), .spiCs(cs1), .spiCk(ck1), .spiDi(mosi1), .spiDo(miso1),
    .busy(busy1)
  );

  int total = 0;
  int bad   = 0;

  int         xCycles;
  int         xChanges;
  int         xRunBad;
  logic [7:0] stsMid;
  logic [7:0] rdDout0, rdDout1;
  logic       rdSel0, rdSel1;

  typedef struct {
    logic [7:0] ctrl;
    logic [7:0] tx;
    logic [7:0] miso;
    logic [1:0] expCs;
    logic [7:0] expSts;
  } vec_t;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] mosi;
    int         cycles;
  } exp_t;

  vec_t vecs[4];
  vec_t vecs1[2];
  exp_t sb[$];
  exp_t e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic popExp(output exp_t x);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      x = '{8'h00, 8'h00, 0};
    end else begin
      x = sb.pop_front();
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((busy0 || busy1) && n < 2000) begin
      n++;
      @(negedge clock);
    end
    if (n >= 2000) check("idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic ioWrite(input logic [7:0] addr, input logic [7:0] data, input int len);
    @(negedge clock);
    a = addr; di = data; iorq = 1'b0; wr = 1'b0;
    repeat (len) @(negedge clock);
    iorq = 1'b1; wr = 1'b1;
  endtask

  task automatic ioRead(input logic [7:0] addr);
    @(negedge clock);
    a = addr; iorq = 1'b0; rd = 1'b0;
    #1;
    rdDout0 = dout0; rdSel0 = sel0; rdDout1 = dout1; rdSel1 = sel1;
    @(negedge clock);
    iorq = 1'b1; rd = 1'b1;
`ifdef SPI_READ_TRIGGER_EN
    waitIdle();
`endif
  endtask

  // Follows one transfer from the first negedge after its start. Acts as the
  // SPI slave (captures MOSI and advances MISO after each rising SCK), times
  // every SCK level, and optionally injects a data write plus a status read.
  task automatic runXfer(input int inst, input int half, input int inj);
    logic prevCk, prevMosi, ckNow, moNow, bzNow;
    int run;
    xCycles = 0; xChanges = 0; xRunBad = 0; run = 0;
    prevCk   = (inst == 0) ? ck0 : ck1;
    prevMosi = (inst == 0) ? mosi0 : mosi1;
    while (xCycles < 2000) begin
      ckNow = (inst == 0) ? ck0 : ck1;
      moNow = (inst == 0) ? mosi0 : mosi1;
      bzNow = (inst == 0) ? busy0 : busy1;
      if (ckNow !== prevCk) begin
        xChanges++;
        if (run != half) xRunBad++;
        run = 1;
        if (ckNow === 1'b1) begin
          if (inst == 0) begin
            cap0 = {cap0[6:0], prevMosi};
            misoSr0 = {misoSr0[6:0], 1'b1};
          end else begin
            cap1 = {cap1[6:0], prevMosi};
            misoSr1 = {misoSr1[6:0], 1'b1};
          end
        end
      end else begin
        run++;
      end
      prevCk = ckNow;
      prevMosi = moNow;
      if (bzNow !== 1'b1) break;
      xCycles++;
      if (inj > 0 && xCycles == inj) begin
        a = 8'hEB; di = 8'h11; iorq = 1'b0; wr = 1'b0;
      end else if (inj > 0 && xCycles == inj + 1) begin
        wr = 1'b1; a = 8'hE7; rd = 1'b0;
        #1 stsMid = dout0;
      end else if (inj > 0 && xCycles == inj + 2) begin
        iorq = 1'b1; rd = 1'b1;
      end
      @(negedge clock);
    end
  endtask

  initial begin
    vecs[0] = '{8'h01, 8'hA5, 8'h3C, 2'b10, 8'h01};
    vecs[1] = '{8'h02, 8'h00, 8'hFF, 2'b01, 8'h02};
    vecs[2] = '{8'h03, 8'hFF, 8'h00, 2'b00, 8'h03};
    vecs[3] = '{8'h84, 8'h3C, 8'hC3, 2'b11, 8'h00};
    vecs1[0] = '{8'h01, 8'h81, 8'hFF, 2'b10, 8'h01};
    vecs1[1] = '{8'h01, 8'h4D, 8'h6B, 2'b10, 8'h01};

    reset = 1'b0; iorq = 1'b1; rd = 1'b1; wr = 1'b1; a = 8'h00; di = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Reset state.
    check("rst_cs0", 32'(cs0), 32'h3);
    check("rst_ck0", 32'(ck0), 32'h0);
    check("rst_mosi0", 32'(mosi0), 32'h1);
    check("rst_busy0", 32'(busy0), 32'h0);
    check("rst_ck1_idle_high", 32'(ck1), 32'h1);
    check("rst_busy1", 32'(busy1), 32'h0);
    ioRead(8'hEB);
    check("rst_rx", 32'(rdDout0), 32'hFF);
    check("rst_sel0", 32'(rdSel0), 32'h1);
    check("rst_sel1_other", 32'(rdSel1), 32'h0);
`ifndef SPI_READ_TRIGGER_EN
    check("read_no_trigger", 32'(busy0), 32'h0);
`endif
    ioRead(8'h00);
    check("nomatch_sel", 32'(rdSel0), 32'h0);
    check("nomatch_do", 32'(rdDout0), 32'hFF);
    ioRead(8'hE7);
    check("rst_status", 32'(rdDout0), 32'h00);

    // Table of mode-0 transfers on instance 0.
    for (int i = 0; i < 4; i++) begin
      ioWrite(8'hE7, vecs[i].ctrl, 3);
      check($sformatf("v%0d_cs", i), 32'(cs0), 32'(vecs[i].expCs));
      misoSr0 = vecs[i].miso;
      cap0 = 8'h00;
      sb.push_back('{vecs[i].miso, vecs[i].tx, 16});
      ioWrite(8'hEB, vecs[i].tx, 1);
      runXfer(0, 1, 0);
      popExp(e);
      check($sformatf("v%0d_busy_cycles", i), 32'(xCycles), 32'(e.cycles));
      check($sformatf("v%0d_sck_edges", i), 32'(xChanges), 32'd16);
      check($sformatf("v%0d_sck_runs", i), 32'(xRunBad), 32'd0);
      check($sformatf("v%0d_mosi", i), 32'(cap0), 32'(e.mosi));
      ioRead(8'hE7);
      check($sformatf("v%0d_status", i), 32'(rdDout0), 32'(vecs[i].expSts));
      ioRead(8'hEB);
      check($sformatf("v%0d_rx", i), 32'(rdDout0), 32'(e.rx));
    end

    // Data write mid-transfer: dropped, overrun flagged, cleared by ctrl bit 7.
    ioWrite(8'hE7, 8'h01, 1);
    misoSr0 = 8'h5A;
    cap0 = 8'h00;
    ioWrite(8'hEB, 8'h96, 1);
    runXfer(0, 1, 5);
    check("ovr_status_mid", 32'(stsMid), 32'hC1);
    check("ovr_busy_cycles", 32'(xCycles), 32'd16);
    check("ovr_mosi", 32'(cap0), 32'h96);
    ioRead(8'hE7);
    check("ovr_status_idle", 32'(rdDout0), 32'h41);
    ioRead(8'hEB);
    check("ovr_rx", 32'(rdDout0), 32'h5A);
    ioWrite(8'hE7, 8'h80, 1);
    ioRead(8'hE7);
    check("ovr_cleared", 32'(rdDout0), 32'h00);

    // A strobe held for several cycles is one event only.
    misoSr0 = 8'h00;
    ioWrite(8'hEB, 8'h77, 3);
    waitIdle();
    ioRead(8'hE7);
    check("long_strobe_one_event", 32'(rdDout0), 32'h00);

    // Mode 3, DIV=3 on instance 1.
    ioWrite(8'hD7, 8'h01, 2);
    check("m3_cs", 32'(cs1), 32'h2);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("m3_%0d_idle_high", i), 32'(ck1), 32'h1);
      misoSr1 = vecs1[i].miso;
      cap1 = 8'h00;
      sb.push_back('{vecs1[i].miso, vecs1[i].tx, 64});
      ioWrite(8'hDB, vecs1[i].tx, 1);
      runXfer(1, 4, 0);
      popExp(e);
      check($sformatf("m3_%0d_busy_cycles", i), 32'(xCycles), 32'(e.cycles));
      check($sformatf("m3_%0d_sck_edges", i), 32'(xChanges), 32'd16);
      check($sformatf("m3_%0d_sck_runs", i), 32'(xRunBad), 32'd0);
      check($sformatf("m3_%0d_mosi", i), 32'(cap1), 32'(e.mosi));
      check($sformatf("m3_%0d_end_high", i), 32'(ck1), 32'h1);
      ioRead(8'hDB);
      check($sformatf("m3_%0d_rx", i), 32'(rdDout1), 32'(e.rx));
      check($sformatf("m3_%0d_sel", i), 32'(rdSel1), 32'h1);
    end
    ioRead(8'hD7);
    check("m3_status", 32'(rdDout1), 32'(vecs1[1].expSts));

`ifdef SPI_READ_TRIGGER_EN
    // Pipelined read: returns old rx, sends 8'hFF, captures the new byte.
    misoSr0 = 8'h3C;
    ioWrite(8'hEB, 8'hA5, 1);
    runXfer(0, 1, 0);
    misoSr0 = 8'h5A;
    cap0 = 8'h00;
    @(negedge clock);
    a = 8'hEB; iorq = 1'b0; rd = 1'b0;
    #1 rdDout0 = dout0;
    @(negedge clock);
    iorq = 1'b1; rd = 1'b1;
    check("trig_old_rx", 32'(rdDout0), 32'h3C);
    runXfer(0, 1, 0);
    check("trig_busy_cycles", 32'(xCycles), 32'd16);
    check("trig_mosi_ff", 32'(cap0), 32'hFF);
    ioRead(8'hEB);
    check("trig_new_rx", 32'(rdDout0), 32'h5A);
    ioRead(8'hE7);
    check("trig_no_ovr", 32'(rdDout0), 32'h00);
`endif

    // Reset during a transfer aborts it at once.
    ioWrite(8'hE7, 8'h02, 1);
    misoSr0 = 8'h00;
    ioWrite(8'hEB, 8'h55, 1);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("abort_busy", 32'(busy0), 32'h0);
    check("abort_ck0", 32'(ck0), 32'h0);
    check("abort_cs0", 32'(cs0), 32'h3);
    check("abort_mosi0", 32'(mosi0), 32'h1);
    check("abort_ck1", 32'(ck1), 32'h1);
    check("abort_cs1", 32'(cs1), 32'h3);
    reset = 1'b1;
    ioRead(8'hEB);
    check("abort_rx", 32'(rdDout0), 32'hFF);
    ioRead(8'hE7);
    check("abort_status", 32'(rdDout0), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
